// File: rtl/mult_sched_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mult_sched_pkg : shared sizes and S1 operand record                 |
// | rev 1.0                                                             |
// +--------------------------------------------------------------------+
package mult_sched_pkg;

  localparam int NUM_REQ = 4;
  localparam int OP_W    = 8;
  localparam int ID_W    = 2;

  typedef struct packed {
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
    logic [ID_W-1:0] id;
  } s1_rec_t;

endpackage
`default_nettype wire

// File: rtl/mult_share_scheduler_mult.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | wallace_unsigned_multiplier_CLA_Reduced_8 : 8x8 unsigned multiplier |
// | Wallace carry-save reduction, carry-lookahead final add. rev 1.0    |
// +--------------------------------------------------------------------+
module wallace_unsigned_multiplier_CLA_Reduced_8 (
  input  logic [7:0]  a_i,
  input  logic [7:0]  b_i,
  output logic [15:0] product_o
);

  logic [15:0] pp [8];
  logic [15:0] s0, c0, s1, c1, s2, c2, s3, c3, s4, c4, s5, c5;

  // Reduction is done modulo 2^16; the true product always fits, so no bits are lost.
  function automatic logic [15:0] csa_s(input logic [15:0] x, input logic [15:0] y,
                                        input logic [15:0] z);
    return x ^ y ^ z;
  endfunction

  function automatic logic [15:0] csa_c(input logic [15:0] x, input logic [15:0] y,
                                        input logic [15:0] z);
    return ((x & y) | (x & z) | (y & z)) << 1;
  endfunction

  function automatic logic [15:0] cla16(input logic [15:0] x, input logic [15:0] y);
    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] c;
    logic [3:0]  gc;
    logic        gg;
    logic        gp;
    g  = x & y;
    p  = x ^ y;
    c  = '0;
    gc = '0;
    for (int k = 0; k < 4; k++) begin
      gg = 1'b0;
      gp = 1'b1;
      for (int j = 0; j < 4; j++) begin
        gg = g[4*k+j] | (p[4*k+j] & gg);
        gp = gp & p[4*k+j];
      end
      c[4*k] = gc[k];
      for (int j = 1; j < 4; j++) begin
        c[4*k+j] = g[4*k+j-1] | (p[4*k+j-1] & c[4*k+j-1]);
      end
      if (k < 3) gc[k+1] = gg | (gp & gc[k]);
    end
    return p ^ c;
  endfunction

  generate
    for (genvar i = 0; i < 8; i++) begin : g_pp
      assign pp[i] = b_i[i] ? (16'(a_i) << i) : 16'd0;
    end
  endgenerate

  // 8 -> 6 -> 4 -> 3 -> 2 rows
  assign s0 = csa_s(pp[0], pp[1], pp[2]);
  assign c0 = csa_c(pp[0], pp[1], pp[2]);
  assign s1 = csa_s(pp[3], pp[4], pp[5]);
  assign c1 = csa_c(pp[3], pp[4], pp[5]);
  assign s2 = csa_s(s0, c0, s1);
  assign c2 = csa_c(s0, c0, s1);
  assign s3 = csa_s(c1, pp[6], pp[7]);
  assign c3 = csa_c(c1, pp[6], pp[7]);
  assign s4 = csa_s(s2, c2, s3);
  assign c4 = csa_c(s2, c2, s3);
  assign s5 = csa_s(s4, c4, c3);
  assign c5 = csa_c(s4, c4, c3);

  assign product_o = cla16(s5, c5);

endmodule
`default_nettype wire

// File: rtl/mult_share_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mult_share_scheduler : round-robin sharing of one multiplier        |
// | between four requesters, 2-stage pipeline. rev 1.0                  |
// +--------------------------------------------------------------------+
module mult_share_scheduler #(
  parameter int NUM_REQ = mult_sched_pkg::NUM_REQ,
  parameter int OP_W    = mult_sched_pkg::OP_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  input  logic [NUM_REQ*OP_W-1:0]        req_a_i,
  input  logic [NUM_REQ*OP_W-1:0]        req_b_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  output logic                           rsp_valid_o,
  input  logic                           rsp_ready_i,
  output logic [2*OP_W-1:0]              rsp_product_o,
  output logic [mult_sched_pkg::ID_W-1:0] rsp_id_o,
  output logic                           busy_o
);

  import mult_sched_pkg::*;

  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic              s1_valid_q, s1_valid_d;
  s1_rec_t           s1_q, s1_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [2*OP_W-1:0] rsp_product_q, rsp_product_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;

  logic [2*OP_W-1:0] mult_product;
  logic              grant_any;
  logic [ID_W-1:0]   grant_idx;
  logic [ID_W-1:0]   scan_idx;
  logic              s2_load;
  logic              s1_accept;
  logic              xfer;

  assign s2_load   = !rsp_valid_q || rsp_ready_i;
  assign s1_accept = !s1_valid_q || s2_load;

  // Scan from the far end so the requester closest to ptr wins last.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = ptr_q;
    scan_idx  = ptr_q;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      scan_idx = ptr_q + ID_W'(k);
      if (req_valid_i[scan_idx]) begin
        grant_any = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  assign xfer = grant_any && s1_accept && !rst;

  always_comb begin
    req_ready_o = '0;
    if (xfer) req_ready_o[grant_idx] = 1'b1;
  end

  always_comb begin
    ptr_d         = ptr_q;
    s1_valid_d    = s1_valid_q;
    s1_d          = s1_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_product_d = rsp_product_q;
    rsp_id_d      = rsp_id_q;

    if (xfer) ptr_d = grant_idx + ID_W'(1);

    if (s1_accept) begin
      s1_valid_d = xfer;
      if (xfer) begin
        s1_d.a  = req_a_i[int'(grant_idx)*OP_W +: OP_W];
        s1_d.b  = req_b_i[int'(grant_idx)*OP_W +: OP_W];
        s1_d.id = grant_idx;
      end
    end

    // S2 data is only refreshed by a real operand; an empty S1 just drops valid.
    if (s2_load) begin
      rsp_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        rsp_product_d = mult_product;
        rsp_id_d      = s1_q.id;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q         <= '0;
      s1_valid_q    <= 1'b0;
      s1_q          <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_product_q <= '0;
      rsp_id_q      <= '0;
    end else begin
      ptr_q         <= ptr_d;
      s1_valid_q    <= s1_valid_d;
      s1_q          <= s1_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_product_q <= rsp_product_d;
      rsp_id_q      <= rsp_id_d;
    end
  end

  wallace_unsigned_multiplier_CLA_Reduced_8 u_mult (
    .a_i       (s1_q.a),
    .b_i       (s1_q.b),
    .product_o (mult_product)
  );

  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_product_o = rsp_product_q;
  assign rsp_id_o      = rsp_id_q;
  assign busy_o        = !rst && (s1_valid_q || rsp_valid_q);

endmodule
`default_nettype wire
